program_memory_loader: RTL and testbench
========================================

Name: program_memory_loader

Overview:
- Program-memory responder for the control unit's instruction-fetch interface.
- Holds the 16-bit program words that the control unit addresses through program_data_address, and returns them on program_data.
- Contains a byte-serial boot loader (valid/ready) that fills memory from a host, then asserts cu_enable to release the control unit.
- Sits between the host/debug port and the control unit; it is the other end of the program_data / program_data_address pair.

Parameters:
- DATA_WIDTH, 16 (`program_data_size): program word width.
- ADDR_WIDTH, 8 (`program_data_max_length): fetch/write address width.
- DEPTH, 256: words stored, equal to 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- program_data_address  in  ADDR_WIDTH  fetch address from the control unit.
- program_data  out  DATA_WIDTH  registered instruction word to the control unit.
- cu_enable  out  1  drives the control unit's enable input; high only in RUN.
- load_start  in  1  single-cycle request to begin a load.
- load_length  in  ADDR_WIDTH  sampled with load_start; words to load = load_length+1 (range 1..256).
- load_byte  in  8  host data byte.
- load_valid  in  1  load_byte is valid.
- load_ready  out  1  loader accepts a byte this cycle.
- load_done  out  1  one-cycle pulse when the last word has been written.
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current or last load.

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state=IDLE; program_data=0; cu_enable=0; load_ready=0; load_done=0; words_loaded=0; write pointer=0.
  - Memory contents are not cleared.
- FSM states: IDLE, LOAD_LO, LOAD_HI, RUN.
- IDLE:
  - cu_enable=0, load_ready=0, program_data=0.
  - load_start=1: latch last_addr=load_length, set pointer=0 and words_loaded=0, go to LOAD_LO.
- LOAD_LO:
  - load_ready=1.
  - On load_valid&&load_ready, capture the low byte and go to LOAD_HI.
  - No timeout: the FSM waits indefinitely.
- LOAD_HI:
  - load_ready=1.
  - On handshake, write mem[pointer] <= {load_byte, low_byte} (little-endian byte order) and increment words_loaded.
  - If pointer==last_addr: go to RUN and pulse load_done this cycle.
  - Else: pointer+1, go to LOAD_LO.
- Byte throughput: back-to-back handshakes are legal, so the loader accepts one byte per cycle and one word per 2 cycles.
- Ready is not withdrawn mid-word.
- RUN:
  - cu_enable=1, load_ready=0.
  - program_data <= mem[program_data_address] every cycle: 1-cycle registered read latency.
  - Address wrap: 8-bit wrap is natural (255 -> 0); there is no out-of-range condition.
- load_start in LOAD_LO/LOAD_HI: ignored, and the load in progress continues.
- load_start in RUN (reload):
  - Takes effect at the same edge: cu_enable=0 and program_data=0, go to LOAD_LO.
  - The new load_length is latched.
- load_valid outside LOAD_LO/LOAD_HI: ignored, and no byte is consumed.
- Reset mid-load:
  - Returns to IDLE immediately.
  - Words already written remain in memory; words_loaded=0.
- Length boundaries:
  - load_length=0 loads exactly 1 word (2 bytes).
  - load_length=255 loads 256 words and ends with pointer=255 (no wrap during load).

Decomposition:
- Shared params.v additions: `LOADER_IDLE/LOAD_LO/LOAD_HI/RUN state encodings (2 bits). Reuse `program_data_size and `program_data_max_length.
- One sub-module: program_ram
  - Single write port, single registered read port, DEPTH x DATA_WIDTH, no reset on the array.
  - Synthesizes to block RAM.
- The FSM, pointer and counters stay in program_memory_loader.

Test Plan:
- Reset → all outputs 0 and state IDLE. Then load_start with load_length=0 and bytes 0x34, 0x12 → load_done pulses one cycle after the 2nd handshake, cu_enable=1, addr 0 reads 0x1234 one cycle later.
- load_length=3, bytes streamed with load_valid held high for 8 cycles → load_ready stays high throughout, words_loaded=4, mem[0..3] match, RUN entered.
- Same load with random load_valid gaps → identical memory contents; no byte is lost or duplicated.
- load_length=255 with 512 bytes → words_loaded=256. Address 255 then 0 in RUN returns the correct words, showing wrap.
- load_start in RUN → cu_enable drops at the same edge and program_data=0. Reload 2 words, then verify new data at addr 0..1 and old data retained at addr 2.
- Reset asserted asynchronously between the LO and HI byte → immediate IDLE, words_loaded=0, cu_enable=0. Earlier words are preserved, and the half word is not written.

Source files
------------

// File: rtl/program_memory_loader_pkg.sv
// ---------------------------------------------------------------------------
// program_memory_loader_pkg
// Shared widths, loader state encoding and a byte-packing helper for the
// program memory loader and its RAM.
// ---------------------------------------------------------------------------
package program_memory_loader_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ADDR_WIDTH = 8;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int BYTE_WIDTH = 8;

    typedef enum logic [1:0] {
        LOADER_IDLE    = 2'd0,
        LOADER_LOAD_LO = 2'd1,
        LOADER_LOAD_HI = 2'd2,
        LOADER_RUN     = 2'd3
    } loader_state_e;

    // Host sends the low byte first, so the word is {second byte, first byte}.
    function automatic logic [DATA_WIDTH-1:0] pack_word(
        input logic [BYTE_WIDTH-1:0] hi_byte,
        input logic [BYTE_WIDTH-1:0] lo_byte
    );
        return {hi_byte, lo_byte};
    endfunction

endpackage

// File: rtl/program_memory_loader_if.sv
// ---------------------------------------------------------------------------
// program_memory_loader_if
// Bundles the instruction-fetch pair and the byte-serial boot loader port.
//   slave  : the program memory loader (responds to fetches, accepts bytes)
//   master : the control unit / host side
// Signals:
//   program_data_address  fetch address          (master -> slave)
//   program_data          registered fetch word  (slave -> master)
//   cu_enable             release of the control unit
//   load_start/load_length  load request and (words-1)
//   load_byte/load_valid/load_ready  byte handshake
//   load_done             one-cycle end-of-load pulse
//   words_loaded          words written in current/last load
// ---------------------------------------------------------------------------
interface program_memory_loader_if;
    import program_memory_loader_pkg::*;

    logic [ADDR_WIDTH-1:0] program_data_address;
    logic [DATA_WIDTH-1:0] program_data;
    logic                  cu_enable;
    logic                  load_start;
    logic [ADDR_WIDTH-1:0] load_length;
    logic [BYTE_WIDTH-1:0] load_byte;
    logic                  load_valid;
    logic                  load_ready;
    logic                  load_done;
    logic [ADDR_WIDTH:0]   words_loaded;

    modport slave (
        input  program_data_address,
        input  load_start,
        input  load_length,
        input  load_byte,
        input  load_valid,
        output program_data,
        output cu_enable,
        output load_ready,
        output load_done,
        output words_loaded
    );

    modport master (
        output program_data_address,
        output load_start,
        output load_length,
        output load_byte,
        output load_valid,
        input  program_data,
        input  cu_enable,
        input  load_ready,
        input  load_done,
        input  words_loaded
    );

endinterface

// File: rtl/program_memory_loader_program_ram.sv
// ---------------------------------------------------------------------------
// program_memory_loader_program_ram
// DEPTH x DATA_WIDTH program store: one write port, one registered read port.
// The array itself is never reset so it maps onto block RAM; only the output
// register is reset. When rd_en_i is low the output register loads zero,
// which is how the fetch word is held at 0 outside RUN.
// Ports:
//   clk, rst_n         clock, async active-low reset (output register only)
//   wr_en_i/addr/data  write port
//   rd_en_i/rd_addr_i  read request and address
//   rd_data_o          registered read data (1-cycle latency)
// ---------------------------------------------------------------------------
module program_memory_loader_program_ram
    import program_memory_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/program_memory_loader.sv
// ---------------------------------------------------------------------------
// program_memory_loader
// Program memory for the control unit plus a byte-serial boot loader. The
// host streams little-endian byte pairs; once load_length+1 words are written
// the block enters RUN, raises cu_enable and serves fetches with one cycle of
// registered read latency.
//
//   state          | meaning
//   ---------------+----------------------------------------------------
//   LOADER_IDLE    | after reset, waiting for load_start
//   LOADER_LOAD_LO | waiting for the low byte of word[ptr]
//   LOADER_LOAD_HI | waiting for the high byte; writes word[ptr]
//   LOADER_RUN     | cu_enable high, fetches served; load_start reloads
//
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    program_memory_loader_if.slave (fetch + loader signals)
// ---------------------------------------------------------------------------
module program_memory_loader
    import program_memory_loader_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    program_memory_loader_if.slave bus
);

    loader_state_e         state_q, state_d;
    logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic [BYTE_WIDTH-1:0] lo_byte_q, lo_byte_d;
    logic                  cu_enable_q, cu_enable_d;
    logic                  load_ready_q, load_ready_d;
    logic                  load_done_q, load_done_d;

    logic                  handshake;
    logic                  wr_en;
    logic                  rd_en;

    assign handshake = bus.load_valid && load_ready_q;
    assign wr_en     = (state_q == LOADER_LOAD_HI) && handshake;
    // A reload request in RUN must zero the fetch word at the same edge.
    assign rd_en     = (state_q == LOADER_RUN) && !bus.load_start;

    always_comb begin
        state_d      = state_q;
        last_addr_d  = last_addr_q;
        ptr_d        = ptr_q;
        words_d      = words_q;
        lo_byte_d    = lo_byte_q;
        cu_enable_d  = cu_enable_q;
        load_ready_d = load_ready_q;
        load_done_d  = 1'b0;

        case (state_q)
            LOADER_IDLE, LOADER_RUN: begin
                if (bus.load_start) begin
                    last_addr_d  = bus.load_length;
                    ptr_d        = '0;
                    words_d      = '0;
                    cu_enable_d  = 1'b0;
                    load_ready_d = 1'b1;
                    state_d      = LOADER_LOAD_LO;
                end
            end
            LOADER_LOAD_LO: begin
                if (handshake) begin
                    lo_byte_d = bus.load_byte;
                    state_d   = LOADER_LOAD_HI;
                end
            end
            LOADER_LOAD_HI: begin
                if (handshake) begin
                    words_d = words_q + 1'b1;
                    if (ptr_q == last_addr_q) begin
                        load_ready_d = 1'b0;
                        cu_enable_d  = 1'b1;
                        load_done_d  = 1'b1;
                        state_d      = LOADER_RUN;
                    end else begin
                        ptr_d   = ptr_q + 1'b1;
                        state_d = LOADER_LOAD_LO;
                    end
                end
            end
            default: begin
                state_d = LOADER_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= LOADER_IDLE;
            last_addr_q  <= '0;
            ptr_q        <= '0;
            words_q      <= '0;
            lo_byte_q    <= '0;
            cu_enable_q  <= 1'b0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_addr_q  <= last_addr_d;
            ptr_q        <= ptr_d;
            words_q      <= words_d;
            lo_byte_q    <= lo_byte_d;
            cu_enable_q  <= cu_enable_d;
            load_ready_q <= load_ready_d;
            load_done_q  <= load_done_d;
        end
    end

    program_memory_loader_program_ram u_program_ram (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en_i   (wr_en),
        .wr_addr_i (ptr_q),
        .wr_data_i (pack_word(bus.load_byte, lo_byte_q)),
        .rd_en_i   (rd_en),
        .rd_addr_i (bus.program_data_address),
        .rd_data_o (bus.program_data)
    );

    assign bus.cu_enable    = cu_enable_q;
    assign bus.load_ready   = load_ready_q;
    assign bus.load_done    = load_done_q;
    assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// ---------------------------------------------------------------------------
// tb_program_memory_loader
// Random-stimulus bench with a scoreboard: loads push expected end-of-load
// word counts and reads push expected words from an array model of memory;
// a monitor on the falling edge pops and compares as the DUT responds.
// ---------------------------------------------------------------------------
module tb_program_memory_loader;
    import program_memory_loader_pkg::*;

    typedef logic [7:0]  bq_t [$];
    typedef logic [15:0] wq_t [$];
    typedef int          iq_t [$];

    logic clk = 1'b0;
    logic reset;
    program_memory_loader_if bus ();

    program_memory_loader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] ref_mem [256];
    logic [15:0] exp_rd_q [$];
    int          exp_done_q [$];
    bit          rd_req = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: read data appears one cycle after the request cycle; load_done
    // is matched against the expected word count of the load that was issued.
    initial begin
        bit          pend;
        bit          prev_done;
        logic [15:0] e_word;
        int          e_cnt;
        pend      = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (exp_rd_q.size() == 0) begin
                    check("rd_underflow", 1, 0);
                end else begin
                    e_word = exp_rd_q.pop_front();
                    check("rd_data", bus.program_data, e_word);
                end
            end
            pend = rd_req;
            if (prev_done) begin
                check("done_width", bus.load_done, 0);
            end else if (bus.load_done === 1'b1) begin
                if (exp_done_q.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    e_cnt = exp_done_q.pop_front();
                    check("done_words", bus.words_loaded, e_cnt);
                    check("done_cu_enable", bus.cu_enable, 1);
                end
            end
            prev_done = (bus.load_done === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic send_bytes(input bq_t bytes, input int gap_pct, input int inject_cyc);
        int i;
        int cyc;
        bit give;
        bit hs;
        i   = 0;
        cyc = 0;
        while (i < bytes.size()) begin
            give            = ($urandom_range(0, 99) >= gap_pct);
            bus.load_valid  = give;
            bus.load_byte   = give ? bytes[i] : 8'($urandom);
            bus.load_start  = (cyc == inject_cyc);
            bus.load_length = 8'($urandom);
            if (gap_pct == 0) check("ready_held", bus.load_ready, 1);
            hs = give && (bus.load_ready === 1'b1);
            @(posedge clk);
            #1;
            if (hs) i++;
            cyc++;
            if (cyc > 4000) begin
                check("byte_timeout", 0, 1);
                break;
            end
        end
        bus.load_valid = 1'b0;
        bus.load_start = 1'b0;
    endtask

    // abort_bytes < 0 sends the whole image; otherwise only that many bytes.
    task automatic do_load(input int len, input wq_t words, input int gap_pct,
                           input int abort_bytes, input int inject_cyc);
        bq_t bytes;
        int  nbytes;
        bus.load_start  = 1'b1;
        bus.load_length = 8'(len);
        @(posedge clk);
        #1;
        bus.load_start = 1'b0;
        check("start_cu_enable", bus.cu_enable, 0);
        check("start_program_data", bus.program_data, 0);
        check("start_ready", bus.load_ready, 1);
        check("start_words", bus.words_loaded, 0);
        foreach (words[k]) begin
            bytes.push_back(words[k][7:0]);
            bytes.push_back(words[k][15:8]);
        end
        nbytes = (abort_bytes >= 0) ? abort_bytes : bytes.size();
        while (bytes.size() > nbytes) void'(bytes.pop_back());
        if (abort_bytes < 0) exp_done_q.push_back(len + 1);
        send_bytes(bytes, gap_pct, inject_cyc);
        for (int k = 0; k < nbytes / 2; k++) ref_mem[k] = words[k];
        if (abort_bytes < 0) begin
            for (int t = 0; t < 6 && exp_done_q.size() != 0; t++) @(negedge clk);
            check("done_seen", exp_done_q.size(), 0);
            @(posedge clk);
            #1;
            check("run_cu_enable", bus.cu_enable, 1);
            check("run_ready", bus.load_ready, 0);
            check("run_words", bus.words_loaded, len + 1);
        end
    endtask

    task automatic do_reads(input iq_t addrs);
        foreach (addrs[k]) begin
            bus.program_data_address = 8'(addrs[k]);
            rd_req = 1'b1;
            exp_rd_q.push_back(ref_mem[addrs[k]]);
            @(posedge clk);
            #1;
        end
        rd_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rd_drained", exp_rd_q.size(), 0);
    endtask

    function automatic wq_t rand_words(input int n);
        wq_t w;
        for (int k = 0; k < n; k++) w.push_back(16'($urandom_range(1, 65535)));
        return w;
    endfunction

    initial begin
        wq_t w;
        wq_t wa;
        iq_t rd;
        bus.program_data_address = '0;
        bus.load_start  = 1'b0;
        bus.load_length = '0;
        bus.load_byte   = '0;
        bus.load_valid  = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2;
        check("rst_program_data", bus.program_data, 0);
        check("rst_cu_enable", bus.cu_enable, 0);
        check("rst_ready", bus.load_ready, 0);
        check("rst_done", bus.load_done, 0);
        check("rst_words", bus.words_loaded, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;

        // Bytes offered while idle must not be consumed.
        for (int k = 0; k < 3; k++) begin
            bus.load_valid = 1'b1;
            bus.load_byte  = 8'hAA;
            check("idle_ready", bus.load_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.load_valid = 1'b0;

        // Single word, bytes 0x34 then 0x12.
        w = {16'h1234};
        do_load(0, w, 0, -1, -1);
        rd = {0};
        do_reads(rd);

        // Four words, valid held high.
        wa = rand_words(4);
        do_load(3, wa, 0, -1, -1);
        rd = {0, 1, 2, 3};
        do_reads(rd);

        // Bytes offered in RUN are ignored.
        for (int k = 0; k < 4; k++) begin
            bus.load_valid = 1'b1;
            bus.load_byte  = 8'($urandom);
            check("run_ready_low", bus.load_ready, 0);
            @(posedge clk);
            #1;
        end
        bus.load_valid = 1'b0;

        // Same image with random gaps and a stray load_start mid-load.
        do_load(3, wa, 40, -1, 3);
        rd = {3, 2, 1, 0};
        do_reads(rd);

        // Full 256-word image, then wrap-around fetches.
        w = rand_words(256);
        do_load(255, w, 20, -1, -1);
        rd = {255, 0, 254, 255, 0, 1};
        for (int k = 0; k < 6; k++) rd.push_back(int'($urandom_range(0, 255)));
        do_reads(rd);

        // Reload of two words; address 2 keeps its old word.
        w = rand_words(2);
        do_load(1, w, 10, -1, -1);
        rd = {0, 1, 2};
        do_reads(rd);

        // Reset between low and high byte of the third word.
        w = rand_words(4);
        do_load(3, w, 0, 5, -1);
        #2 reset = 1'b0;
        #1;
        check("abort_cu_enable", bus.cu_enable, 0);
        check("abort_words", bus.words_loaded, 0);
        check("abort_ready", bus.load_ready, 0);
        check("abort_done", bus.load_done, 0);
        check("abort_program_data", bus.program_data, 0);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_idle_ready", bus.load_ready, 0);
        w = rand_words(1);
        do_load(0, w, 0, -1, -1);
        rd = {0, 1, 2, 3};
        do_reads(rd);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
